// File: rtl/eight_three_encoder.sv
// Registered 8-to-3 priority encoder with enable.
// Bit 7 has highest priority; also flags any/multiple requests.
module eight_three_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] In,
    input  logic       En,
    output logic [2:0] Out,
    output logic       Valid,
    output logic       Multi
);

    logic [2:0] out_q, out_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;

    logic [2:0] idx;
    logic       any_req;
    logic       multi_req;

    always_comb begin
        idx = 3'd0;
        // Ascending scan: the last hit wins, so bit 7 has top priority.
        for (int i = 0; i < 8; i++) begin
            if (In[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any_req   = |In;
    // Clearing the lowest set bit leaves something iff two or more were set.
    assign multi_req = |(In & (In - 8'd1));

    always_comb begin
        out_d   = 3'd0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        if (En && any_req) begin
            out_d   = idx;
            valid_d = 1'b1;
            multi_d = multi_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign Out   = out_q;
    assign Valid = valid_q;
    assign Multi = multi_q;

endmodule

// File: tb/tb_eight_three_encoder.sv
// Bench for eight_three_encoder: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_eight_three_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] In;
    logic       En;
    logic [2:0] Out;
    logic       Valid;
    logic       Multi;

    int tests;
    int fails;

    eight_three_encoder dut (
        .clk  (clk),
        .rst  (rst),
        .In   (In),
        .En   (En),
        .Out  (Out),
        .Valid(Valid),
        .Multi(Multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: highest set position and popcount by repeated halving.
    function automatic logic [4:0] model(input logic [7:0] v,
                                         input logic e,
                                         input logic r);
        int n;
        int cnt;
        int hi;
        int pos;
        logic val;
        logic mul;
        logic [2:0] o;
        n = int'(v);
        cnt = 0;
        hi = 0;
        pos = 0;
        while (n > 0) begin
            if (n % 2 == 1) begin
                cnt++;
                hi = pos;
            end
            n = n / 2;
            pos++;
        end
        val = !r && e && (cnt > 0);
        mul = !r && e && (cnt >= 2);
        o = val ? 3'(hi) : 3'd0;
        return {o, val, mul};
    endfunction

    // Apply inputs, clock once, settle past the edge.
    task automatic drive(input logic [7:0] v, input logic e, input logic r);
        In  = v;
        En  = e;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(8'hFF, 1'b1, 1'b1);
            tests++;
            if ({Out, Valid, Multi} !== 5'b000_0_0) begin
                fails++;
                $display("FAIL reset[%0d]: got %b%b%b want 000 0 0",
                         k, Out, Valid, Multi);
            end
        end
    endtask

    task automatic test_onehot();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 8'd1 << k;
            drive(v, 1'b1, 1'b0);
            tests++;
            if ({Out, Valid, Multi} !== {3'(k), 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL onehot In=%h: got Out=%0d V=%b M=%b want Out=%0d V=1 M=0",
                         v, Out, Valid, Multi, k);
            end
        end
    endtask

    task automatic test_multihot();
        logic [7:0] vecs [4];
        logic [2:0] exp  [4];
        vecs = '{8'b1010_1010, 8'b0101_0010, 8'b0010_1000, 8'b0100_1000};
        exp  = '{3'd7, 3'd6, 3'd5, 3'd6};
        for (int k = 0; k < 4; k++) begin
            drive(vecs[k], 1'b1, 1'b0);
            tests++;
            if ({Out, Valid, Multi} !== {exp[k], 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL multihot In=%b: got Out=%0d V=%b M=%b want Out=%0d V=1 M=1",
                         vecs[k], Out, Valid, Multi, exp[k]);
            end
        end
    endtask

    task automatic test_disable();
        drive(8'b0001_0010, 1'b0, 1'b0);
        tests++;
        if ({Out, Valid, Multi} !== 5'b000_0_0) begin
            fails++;
            $display("FAIL disable: got Out=%0d V=%b M=%b want 0 0 0",
                     Out, Valid, Multi);
        end
        drive(8'b0100_1000, 1'b1, 1'b0);
        tests++;
        if ({Out, Valid, Multi} !== 5'b110_1_1) begin
            fails++;
            $display("FAIL reenable: got Out=%0d V=%b M=%b want 6 1 1",
                     Out, Valid, Multi);
        end
    endtask

    task automatic test_empty();
        drive(8'h00, 1'b1, 1'b0);
        tests++;
        if ({Out, Valid, Multi} !== 5'b000_0_0) begin
            fails++;
            $display("FAIL empty: got Out=%0d V=%b M=%b want 0 0 0",
                     Out, Valid, Multi);
        end
        drive(8'h01, 1'b1, 1'b0);
        tests++;
        if ({Out, Valid, Multi} !== 5'b000_1_0) begin
            fails++;
            $display("FAIL bit0: got Out=%0d V=%b M=%b want 0 1 0",
                     Out, Valid, Multi);
        end
    endtask

    task automatic test_reset_mid();
        logic       rs   [3];
        logic [4:0] exp  [3];
        rs  = '{1'b0, 1'b1, 1'b0};
        exp = '{5'b111_1_0, 5'b000_0_0, 5'b111_1_0};
        for (int k = 0; k < 3; k++) begin
            drive(8'h80, 1'b1, rs[k]);
            tests++;
            if ({Out, Valid, Multi} !== exp[k]) begin
                fails++;
                $display("FAIL reset_mid[%0d]: got %b want %b",
                         k, {Out, Valid, Multi}, exp[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic       e;
        logic       r;
        logic [4:0] exp;
        for (int k = 0; k < 300; k++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 5) == 0) v = 8'd0;
            e = ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 15) == 0);
            exp = model(v, e, r);
            drive(v, e, r);
            tests++;
            if ({Out, Valid, Multi} !== exp) begin
                fails++;
                $display("FAIL random In=%h En=%b rst=%b: got %b want %b",
                         v, e, r, {Out, Valid, Multi}, exp);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        In    = 8'h00;
        En    = 1'b0;
        #2;
        test_reset();
        test_onehot();
        test_multihot();
        test_disable();
        test_empty();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
